// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg
//   Shared definitions for the bit-serial subtractor controller.
//   Holds the FSM state type and its encodings. No ports.
package serial_sub_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  // Binary-encoded controller states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
//   Request/result bundle between a requesting block (master) and the
//   bit-serial subtractor controller (slave).
//   start       master -> slave  request pulse / level
//   a, b        master -> slave  minuend / subtrahend, captured on accept
//   busy        slave -> master  operation in progress
//   done        slave -> master  one-cycle result-valid pulse
//   diff        slave -> master  a - b modulo 2^WIDTH
//   borrow_out  slave -> master  1 when a < b (unsigned)
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_sub_ctrl_bit.sv
// half_sub
//   One-bit half subtractor: d = x - y, b = borrow.
//   x, y in; d, b out. Purely combinational.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

// serial_sub_bit
//   Full-subtractor cell built from two half subtractors plus an OR on the
//   two borrows: d = x - y - bin, bout = borrow out. Purely combinational.
//   x, y, bin in; d, bout out.
module serial_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs0 (
    .x (x),
    .y (y),
    .d (d1),
    .b (b1)
  );

  half_sub u_hs1 (
    .x (d1),
    .y (bin),
    .d (d),
    .b (b2)
  );

  // Both half-stage borrows can never be set together, so OR is exact.
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Sequences one full-subtractor cell to compute diff = a - b (unsigned,
//   modulo 2^WIDTH) one bit per clock, LSB first.
//   clk, rst_n      clock and asynchronous active-low reset
//   bus (slave)     start/a/b request, busy/done/diff/borrow_out result
//   A request is accepted in IDLE or DONE; busy stays high for WIDTH cycles,
//   then done pulses for one cycle with diff/borrow_out, which are held
//   until the next accepted request.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             bf_q,     bf_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             bit_b;
  logic [WIDTH-1:0] res_next;

  serial_sub_bit u_bit (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (bf_q),
    .d    (bit_d),
    .bout (bit_b)
  );

  // New result bit enters at the MSB so that after WIDTH shifts bit 0 is LSB.
  assign res_next = {bit_d, res_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    bf_d     = bf_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          res_sr_d = '0;
          bf_d     = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end

      // start is deliberately ignored here; operands were captured on accept.
      S_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = res_next;
        bf_d     = bit_b;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = res_next;
          borrow_d = bit_b;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      bf_q     <= bf_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Self-checking bench for serial_sub_ctrl at WIDTH=8. Directed cases plus
//   randomized operations checked against plain arithmetic (a-b mod 256, a<b).
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;
  localparam int LIMIT = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock; inputs change and outputs are sampled on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expectation and count the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting negedges. Optionally scramble inputs
  // and start while busy, and release start before the DONE edge.
  task automatic waitDone(output int cycles, input bit toggle, input bit clearStart);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
      if (toggle && bus.done !== 1'b1) begin
        bus.a     = 8'($urandom_range(0, 255));
        bus.b     = 8'($urandom_range(0, 255));
        bus.start = 1'($urandom_range(0, 1));
      end
    end
    if (clearStart) bus.start = 1'b0;
  endtask

  // Full single operation checked against the arithmetic model.
  task automatic runAndCheck(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input bit toggle);
    int          cycles;
    logic [31:0] expDiff;
    logic [31:0] expBorrow;
    expDiff   = (32'(a) - 32'(b)) & 32'hFF;
    expBorrow = (a < b) ? 32'd1 : 32'd0;
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    waitDone(cycles, toggle, 1'b1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
    checkOutput({tag, "_diff"}, 32'(bus.diff), expDiff);
    checkOutput({tag, "_borrow"}, 32'(bus.borrow_out), expBorrow);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_diff_hold"}, 32'(bus.diff), expDiff);
  endtask

  initial begin
    int          cycles;
    int          donePulses;
    logic [31:0] seenDiff;
    logic [7:0]  ra;
    logic [7:0]  rb;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_diff", 32'(bus.diff), 32'd0);
    checkOutput("rst_borrow", 32'(bus.borrow_out), 32'd0);
    rst_n = 1'b1;

    // Basic and boundary operations
    runAndCheck("op_5a_3c", 8'h5A, 8'h3C, 1'b0);
    runAndCheck("op_00_01", 8'h00, 8'h01, 1'b0);
    runAndCheck("op_ff_ff", 8'hFF, 8'hFF, 1'b0);

    // start pulsed while busy must be ignored
    applyStimulus(8'h10, 8'h01);
    donePulses = 0;
    seenDiff   = '0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        donePulses++;
        seenDiff = 32'(bus.diff);
      end
      @(negedge clk);
    end
    checkOutput("ignore_done_count", 32'(donePulses), 32'd1);
    checkOutput("ignore_diff", seenDiff, 32'h0F);
    checkOutput("ignore_borrow", 32'(bus.borrow_out), 32'd0);

    // start held high through DONE: back-to-back acceptance
    applyStimulus(8'h20, 8'h01);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h05;
    waitDone(cycles, 1'b0, 1'b0);
    checkOutput("b2b_first_latency", 32'(cycles), 32'(WIDTH - 2));
    checkOutput("b2b_first_diff", 32'(bus.diff), 32'h1F);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b_second_busy", 32'(bus.busy), 32'd1);
    waitDone(cycles, 1'b0, 1'b1);
    checkOutput("b2b_second_latency", 32'(cycles), 32'(WIDTH));
    checkOutput("b2b_second_diff", 32'(bus.diff), 32'hFE);
    checkOutput("b2b_second_borrow", 32'(bus.borrow_out), 32'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation
    applyStimulus(8'h5A, 8'h3C);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_diff", 32'(bus.diff), 32'd0);
    checkOutput("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) donePulses++;
    end
    checkOutput("midrst_no_done", 32'(donePulses), 32'd0);
    checkOutput("midrst_idle_busy", 32'(bus.busy), 32'd0);
    runAndCheck("after_rst", 8'h81, 8'h7F, 1'b0);

    // Randomized operations with inputs and start scrambled during RUN
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      runAndCheck("rand", ra, rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
